fec_fabric_arbiter: RTL and testbench

Frame-granular arbiter that shares the FEC encoder's 16-bit pipelined Wishbone fabric sink between two packet sources, such as a local frame generator and a forwarded stream. It sits directly in front of the encoder sink port. It grants the fabric to one requester for the whole frame (cyc-bounded), so frames never interleave, and it counts granted frames per requester.

---
 rtl/fec_fabric_arbiter.sv | 133 +++++++++++++
 tb/tb_fec_fabric_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fec_fabric_arbiter.sv
// Frame-granular arbiter that shares the FEC encoder's pipelined Wishbone sink
// between two requesters. A grant lasts from cyc rise to cyc fall, and grant_o mirrors the FSM state.
module fec_fabric_arbiter #(
  parameter int g_round_robin = 1,
  parameter int g_cnt_width   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n,
  input  logic                   snk0_cyc_i,
  input  logic                   snk0_stb_i,
  input  logic                   snk0_we_i,
  input  logic [1:0]             snk0_sel_i,
  input  logic [1:0]             snk0_adr_i,
  input  logic [15:0]            snk0_dat_i,
  output logic                   snk0_ack_o,
  output logic                   snk0_stall_o,
  input  logic                   snk1_cyc_i,
  input  logic                   snk1_stb_i,
  input  logic                   snk1_we_i,
  input  logic [1:0]             snk1_sel_i,
  input  logic [1:0]             snk1_adr_i,
  input  logic [15:0]            snk1_dat_i,
  output logic                   snk1_ack_o,
  output logic                   snk1_stall_o,
  output logic                   src_cyc_o,
  output logic                   src_stb_o,
  output logic                   src_we_o,
  output logic [1:0]             src_sel_o,
  output logic [1:0]             src_adr_o,
  output logic [15:0]            src_dat_o,
  input  logic                   src_ack_i,
  input  logic                   src_stall_i,
  output logic [g_cnt_width-1:0] frm_cnt0_o,
  output logic [g_cnt_width-1:0] frm_cnt1_o,
  output logic [1:0]             grant_o
);

  // Handshake: a beat transfers in a cycle where the granted requester holds
  // cyc and stb high and src_stall_i is low; each beat is answered later by
  // exactly one src_ack_i, and the requester keeps cyc high until the last ack.

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  localparam logic [g_cnt_width-1:0] CNT_ONE = {{(g_cnt_width-1){1'b0}}, 1'b1};

  state_t                 state, state_nxt;
  logic                   last, last_nxt;
  logic                   inc0, inc1;
  logic [g_cnt_width-1:0] frm_cnt0, frm_cnt1;

  always_ff @(posedge clk_i or posedge rst_n) begin
    if (rst_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      frm_cnt0 <= '0;
      frm_cnt1 <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      if (inc0) frm_cnt0 <= frm_cnt0 + CNT_ONE;
      if (inc1) frm_cnt1 <= frm_cnt1 + CNT_ONE;
    end
  end

  always_comb begin
    state_nxt    = state;
    last_nxt     = last;
    inc0         = 1'b0;
    inc1         = 1'b0;
    src_cyc_o    = 1'b0;
    src_stb_o    = 1'b0;
    src_we_o     = 1'b0;
    src_sel_o    = 2'b00;
    src_adr_o    = 2'b00;
    src_dat_o    = 16'h0000;
    snk0_ack_o   = 1'b0;
    snk0_stall_o = 1'b1;
    snk1_ack_o   = 1'b0;
    snk1_stall_o = 1'b1;
    case (state)
      IDLE: begin
        // Contention goes to the port that did not hold the last grant.
        if (snk0_cyc_i && snk1_cyc_i) begin
          state_nxt = (g_round_robin != 0 && !last) ? GNT1 : GNT0;
        end else if (snk0_cyc_i) begin
          state_nxt = GNT0;
        end else if (snk1_cyc_i) begin
          state_nxt = GNT1;
        end
      end
      GNT0: begin
        src_cyc_o    = snk0_cyc_i;
        src_stb_o    = snk0_stb_i;
        src_we_o     = snk0_we_i;
        src_sel_o    = snk0_sel_i;
        src_adr_o    = snk0_adr_i;
        src_dat_o    = snk0_dat_i;
        snk0_ack_o   = src_ack_i;
        snk0_stall_o = src_stall_i;
        if (!snk0_cyc_i) begin
          state_nxt = IDLE;
          last_nxt  = 1'b0;
          inc0      = 1'b1;
        end
      end
      GNT1: begin
        src_cyc_o    = snk1_cyc_i;
        src_stb_o    = snk1_stb_i;
        src_we_o     = snk1_we_i;
        src_sel_o    = snk1_sel_i;
        src_adr_o    = snk1_adr_i;
        src_dat_o    = snk1_dat_i;
        snk1_ack_o   = src_ack_i;
        snk1_stall_o = src_stall_i;
        if (!snk1_cyc_i) begin
          state_nxt = IDLE;
          last_nxt  = 1'b1;
          inc1      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign grant_o    = state;
  assign frm_cnt0_o = frm_cnt0;
  assign frm_cnt1_o = frm_cnt1;

endmodule

// File: tb/tb_fec_fabric_arbiter.sv
// Bench for fec_fabric_arbiter: a round-robin and a fixed-priority (4-bit counter)
// instance share one stimulus stream; each is compared against its own frame-level model.
module tb_fec_fabric_arbiter;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_n;
  logic        snk_cyc[2], snk_stb[2], snk_we[2];
  logic [1:0]  snk_sel[2], snk_adr[2];
  logic [15:0] snk_dat[2];
  logic        src_ack_i, src_stall_i;

  logic        d_cyc[2], d_stb[2], d_we[2];
  logic [1:0]  d_sel[2], d_adr[2], d_grant[2];
  logic [15:0] d_dat[2];
  logic        d_ack0[2], d_stall0[2], d_ack1[2], d_stall1[2];
  logic [15:0] rr_cnt0, rr_cnt1;
  logic [3:0]  fp_cnt0, fp_cnt1;

  fec_fabric_arbiter #(.g_round_robin(1), .g_cnt_width(16)) u_rr (
    .clk_i(clk_i), .rst_n(rst_n),
    .snk0_cyc_i(snk_cyc[0]), .snk0_stb_i(snk_stb[0]), .snk0_we_i(snk_we[0]),
    .snk0_sel_i(snk_sel[0]), .snk0_adr_i(snk_adr[0]), .snk0_dat_i(snk_dat[0]),
    .snk0_ack_o(d_ack0[0]), .snk0_stall_o(d_stall0[0]),
    .snk1_cyc_i(snk_cyc[1]), .snk1_stb_i(snk_stb[1]), .snk1_we_i(snk_we[1]),
    .snk1_sel_i(snk_sel[1]), .snk1_adr_i(snk_adr[1]), .snk1_dat_i(snk_dat[1]),
    .snk1_ack_o(d_ack1[0]), .snk1_stall_o(d_stall1[0]),
    .src_cyc_o(d_cyc[0]), .src_stb_o(d_stb[0]), .src_we_o(d_we[0]),
    .src_sel_o(d_sel[0]), .src_adr_o(d_adr[0]), .src_dat_o(d_dat[0]),
    .src_ack_i(src_ack_i), .src_stall_i(src_stall_i),
    .frm_cnt0_o(rr_cnt0), .frm_cnt1_o(rr_cnt1), .grant_o(d_grant[0])
  );

  fec_fabric_arbiter #(.g_round_robin(0), .g_cnt_width(4)) u_fp (
    .clk_i(clk_i), .rst_n(rst_n),
    .snk0_cyc_i(snk_cyc[0]), .snk0_stb_i(snk_stb[0]), .snk0_we_i(snk_we[0]),
    .snk0_sel_i(snk_sel[0]), .snk0_adr_i(snk_adr[0]), .snk0_dat_i(snk_dat[0]),
    .snk0_ack_o(d_ack0[1]), .snk0_stall_o(d_stall0[1]),
    .snk1_cyc_i(snk_cyc[1]), .snk1_stb_i(snk_stb[1]), .snk1_we_i(snk_we[1]),
    .snk1_sel_i(snk_sel[1]), .snk1_adr_i(snk_adr[1]), .snk1_dat_i(snk_dat[1]),
    .snk1_ack_o(d_ack1[1]), .snk1_stall_o(d_stall1[1]),
    .src_cyc_o(d_cyc[1]), .src_stb_o(d_stb[1]), .src_we_o(d_we[1]),
    .src_sel_o(d_sel[1]), .src_adr_o(d_adr[1]), .src_dat_o(d_dat[1]),
    .src_ack_i(src_ack_i), .src_stall_i(src_stall_i),
    .frm_cnt0_o(fp_cnt0), .frm_cnt1_o(fp_cnt1), .grant_o(d_grant[1])
  );

  // Bus bundle: {cyc,stb,we,sel,adr,dat, ack0,stall0,ack1,stall1, grant}
  localparam logic [28:0] RESET_BUS = {7'b0, 16'h0, 4'b0101, 2'b00};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference model, index 0 = round-robin, 1 = fixed priority.
  int m_owner[2];
  int m_last[2];
  int m_cnt[2][2];

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      m_owner[c] = -1; m_last[c] = 1; m_cnt[c][0] = 0; m_cnt[c][1] = 0;
    end
  endfunction

  function automatic logic [28:0] model_bus(input int c);
    int o;
    logic a0, s0, a1, s1;
    o = m_owner[c];
    if (o < 0) return RESET_BUS;
    a0 = (o == 0) && src_ack_i;  s0 = (o == 0) ? src_stall_i : 1'b1;
    a1 = (o == 1) && src_ack_i;  s1 = (o == 1) ? src_stall_i : 1'b1;
    return {snk_cyc[o], snk_stb[o], snk_we[o], snk_sel[o], snk_adr[o], snk_dat[o],
            a0, s0, a1, s1, (o == 0) ? 2'b01 : 2'b10};
  endfunction

  function automatic void model_update(input int c);
    if (rst_n) begin
      m_owner[c] = -1; m_last[c] = 1; m_cnt[c][0] = 0; m_cnt[c][1] = 0;
    end else if (m_owner[c] < 0) begin
      if (snk_cyc[0] && snk_cyc[1]) m_owner[c] = (c == 0) ? 1 - m_last[c] : 0;
      else if (snk_cyc[0]) m_owner[c] = 0;
      else if (snk_cyc[1]) m_owner[c] = 1;
    end else if (!snk_cyc[m_owner[c]]) begin
      m_cnt[c][m_owner[c]]++;
      m_last[c]  = m_owner[c];
      m_owner[c] = -1;
    end
  endfunction

  function automatic logic [28:0] got_bus(input int c);
    return {d_cyc[c], d_stb[c], d_we[c], d_sel[c], d_adr[c], d_dat[c],
            d_ack0[c], d_stall0[c], d_ack1[c], d_stall1[c], d_grant[c]};
  endfunction

  // Requester masters, encoder-side slave and scoreboard state.
  logic [19:0] exp_q0[$], exp_q1[$];
  int m_frames[2], m_len[2], m_gap[2], m_wait[2], m_out[2];
  int ack_q[$];
  int last_due, cyc_no, ack_dmax, drv;
  bit rand_stall, force_ack;
  int beats_acc[2], acks_seen[2];
  int gnt_order[$], gaps[$];
  int low_run;
  bit seen_hi, stall1_low;
  logic [1:0] prev_grant;

  function automatic int q_size(input int p);
    return (p == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [19:0] q_front(input int p);
    if (q_size(p) == 0) return 20'h0;
    return (p == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  task automatic q_pop(input int p);
    if (p == 0) void'(exp_q0.pop_front());
    else        void'(exp_q1.pop_front());
  endtask

  task automatic fill(input int p);
    for (int i = 0; i < m_len[p]; i++) begin
      if (p == 0) exp_q0.push_back(20'($urandom));
      else        exp_q1.push_back(20'($urandom));
    end
  endtask

  task automatic start_port(input int p, input int frames, input int len, input int gap);
    m_frames[p] = frames; m_len[p] = len; m_gap[p] = gap; m_wait[p] = 0;
    if (frames > 0) fill(p);
  endtask

  task automatic clear_tb();
    for (int p = 0; p < 2; p++) begin
      m_frames[p] = 0; m_wait[p] = 0; m_out[p] = 0; beats_acc[p] = 0; acks_seen[p] = 0;
    end
    exp_q0.delete(); exp_q1.delete(); ack_q.delete();
    gnt_order.delete(); gaps.delete();
    last_due = 0; low_run = 0; seen_hi = 0; stall1_low = 0; prev_grant = 2'b00;
  endtask

  task automatic step();
    logic [19:0] b;
    int o, due;
    for (int p = 0; p < 2; p++) begin
      snk_cyc[p] = (m_frames[p] > 0) && (m_wait[p] == 0);
      snk_stb[p] = snk_cyc[p] && (q_size(p) > 0);
      b = snk_stb[p] ? q_front(p) : 20'h0;
      snk_we[p] = snk_cyc[p]; snk_sel[p] = b[19:18]; snk_adr[p] = b[17:16]; snk_dat[p] = b[15:0];
    end
    src_stall_i = rand_stall ? ($urandom_range(0, 2) == 0) : 1'b0;
    src_ack_i   = force_ack || (ack_q.size() > 0 && ack_q[0] == cyc_no);

    @(negedge clk_i);
    check("rr_bus", 64'(got_bus(0)), 64'(model_bus(0)));
    check("fp_bus", 64'(got_bus(1)), 64'(model_bus(1)));
    check("rr_cnt0", 64'(rr_cnt0), 64'(m_cnt[0][0] % 65536));
    check("rr_cnt1", 64'(rr_cnt1), 64'(m_cnt[0][1] % 65536));
    check("fp_cnt0", 64'(fp_cnt0), 64'(m_cnt[1][0] % 16));
    check("fp_cnt1", 64'(fp_cnt1), 64'(m_cnt[1][1] % 16));
    o = m_owner[drv];
    if (o >= 0 && snk_stb[o] && !src_stall_i) begin
      check("sb_beat", 64'({d_stb[drv], d_sel[drv], d_adr[drv], d_dat[drv]}), 64'({1'b1, q_front(o)}));
      beats_acc[o]++;
    end
    if (d_ack0[drv]) acks_seen[0]++;
    if (d_ack1[drv]) acks_seen[1]++;
    if (!d_stall1[drv]) stall1_low = 1'b1;
    if (d_grant[drv] != 2'b00 && prev_grant == 2'b00) gnt_order.push_back((d_grant[drv] == 2'b01) ? 0 : 1);
    prev_grant = d_grant[drv];
    if (!d_cyc[drv]) low_run++;
    else begin
      if (seen_hi && low_run > 0) gaps.push_back(low_run);
      low_run = 0; seen_hi = 1'b1;
    end

    @(posedge clk_i);
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) if (!snk_cyc[p] && m_wait[p] > 0) m_wait[p]--;
      if (o >= 0 && snk_stb[o] && !src_stall_i) begin
        q_pop(o);
        m_out[o]++;
        due = cyc_no + int'($urandom_range(1, ack_dmax));
        if (due <= last_due) due = last_due + 1;
        ack_q.push_back(due);
        last_due = due;
      end
      if (src_ack_i && !force_ack) begin
        void'(ack_q.pop_front());
        if (o >= 0) m_out[o]--;
      end
      if (o >= 0 && snk_cyc[o] && q_size(o) == 0 && m_out[o] == 0) begin
        m_frames[o]--;
        m_wait[o] = m_gap[o];
        if (m_frames[o] > 0) fill(o);
      end
    end
    model_update(0);
    model_update(1);
    cyc_no++;
    #1;
  endtask

  function automatic bit busy();
    return m_frames[0] > 0 || m_frames[1] > 0 || m_owner[0] >= 0 || m_owner[1] >= 0 || ack_q.size() > 0;
  endfunction

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin step(); n++; end
    check("timeout", 64'(busy()), 64'(0));
    step();
  endtask

  task automatic async_reset();
    rst_n = 1'b1;
    #1;
    model_reset();
    clear_tb();
    force_ack = 1'b0;
  endtask

  task automatic do_reset();
    async_reset();
    step();
    step();
    rst_n = 1'b0;
    clear_tb();
  endtask

  typedef struct {
    int         pre;
    bit         c0;
    bit         c1;
    logic [1:0] exp_rr;
    logic [1:0] exp_fp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_b[2], exp_f[2], l0, l1, f0, f1;

    vecs[0] = '{0, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[1] = '{0, 1'b1, 1'b0, 2'b01, 2'b01};
    vecs[2] = '{0, 1'b0, 1'b1, 2'b10, 2'b10};
    vecs[3] = '{0, 1'b1, 1'b1, 2'b01, 2'b01};
    vecs[4] = '{1, 1'b1, 1'b1, 2'b10, 2'b01};
    vecs[5] = '{2, 1'b1, 1'b1, 2'b01, 2'b01};
    vecs[6] = '{1, 1'b0, 1'b1, 2'b10, 2'b10};

    for (int p = 0; p < 2; p++) begin
      snk_cyc[p] = 0; snk_stb[p] = 0; snk_we[p] = 0; snk_sel[p] = 0; snk_adr[p] = 0; snk_dat[p] = 0;
    end
    src_ack_i = 0; src_stall_i = 0; force_ack = 0; rand_stall = 0; ack_dmax = 1; drv = 0; cyc_no = 0;
    model_reset();
    clear_tb();

    // Power-up reset values.
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    #1;
    for (int c = 0; c < 2; c++) check("reset_bus", 64'(got_bus(c)), 64'(RESET_BUS));
    check("reset_cnt", 64'({rr_cnt0, rr_cnt1, fp_cnt0, fp_cnt1}), 64'(0));
    step();
    rst_n = 1'b0;

    // Arbitration decision table.
    foreach (vecs[i]) begin
      do_reset();
      if (vecs[i].pre > 0) begin
        start_port(vecs[i].pre - 1, 1, 2, 1);
        run_until_idle(100);
      end
      if (vecs[i].c0) start_port(0, 1, 1, 1);
      if (vecs[i].c1) start_port(1, 1, 1, 1);
      step();
      check("tbl_grant_rr", 64'(d_grant[0]), 64'(vecs[i].exp_rr));
      check("tbl_grant_fp", 64'(d_grant[1]), 64'(vecs[i].exp_fp));
      run_until_idle(100);
    end

    // Single 32-beat frame on port 0, no stalls.
    do_reset();
    drv = 0; rand_stall = 0; ack_dmax = 1;
    start_port(0, 1, 32, 1);
    run_until_idle(200);
    check("single_beats", 64'(beats_acc[0]), 64'(32));
    check("single_acks", 64'(acks_seen[0]), 64'(32));
    check("single_cnt0", 64'(rr_cnt0), 64'(1));
    check("single_stall1", 64'(stall1_low), 64'(0));

    // Round-robin contention, three frames each.
    do_reset();
    start_port(0, 3, 4, 1);
    start_port(1, 3, 4, 1);
    run_until_idle(400);
    check("rr_order_len", 64'(gnt_order.size()), 64'(6));
    foreach (gnt_order[i]) check("rr_order", 64'(gnt_order[i]), 64'(i % 2));
    check("rr_gap_cnt", 64'(gaps.size()), 64'(5));
    foreach (gaps[i]) check("rr_gap", 64'(gaps[i]), 64'(2));
    check("rr_frames0", 64'(rr_cnt0), 64'(3));
    check("rr_frames1", 64'(rr_cnt1), 64'(3));

    // Fixed priority: port 0 keeps re-requesting, port 1 waits with stb held.
    do_reset();
    drv = 1;
    start_port(0, 3, 3, 1);
    start_port(1, 1, 3, 1);
    run_until_idle(400);
    check("fp_order_len", 64'(gnt_order.size()), 64'(4));
    for (int i = 0; i < gnt_order.size(); i++) check("fp_order", 64'(gnt_order[i]), 64'((i == 3) ? 1 : 0));
    check("fp_beats1", 64'(beats_acc[1]), 64'(3));
    check("fp_frames", 64'({fp_cnt0, fp_cnt1}), 64'({4'd3, 4'd1}));
    drv = 0;

    // Random stalls and ack delays up to 4 cycles.
    do_reset();
    rand_stall = 1; ack_dmax = 4;
    exp_b = '{0, 0}; exp_f = '{0, 0};
    for (int it = 0; it < 5; it++) begin
      l0 = $urandom_range(0, 10); l1 = $urandom_range(0, 10);
      f0 = $urandom_range(1, 2);  f1 = $urandom_range(0, 2);
      start_port(0, f0, l0, 1);
      if (f1 > 0) start_port(1, f1, l1, $urandom_range(1, 3));
      exp_b[0] += f0 * l0; exp_b[1] += f1 * l1;
      exp_f[0] += f0;      exp_f[1] += f1;
      run_until_idle(3000);
    end
    for (int p = 0; p < 2; p++) begin
      check("rand_beats", 64'(beats_acc[p]), 64'(exp_b[p]));
      check("rand_acks", 64'(acks_seen[p]), 64'(exp_b[p]));
    end
    check("rand_cnt0", 64'(rr_cnt0), 64'(exp_f[0]));
    check("rand_cnt1", 64'(rr_cnt1), 64'(exp_f[1]));
    rand_stall = 0; ack_dmax = 1;

    // Ack arriving while idle is not routed.
    force_ack = 1'b1;
    step();
    check("idle_ack", 64'({d_ack0[0], d_ack1[0], d_ack0[1], d_ack1[1]}), 64'(0));
    step();
    force_ack = 1'b0;

    // Reset at beat 10 of a port-1 frame.
    do_reset();
    start_port(1, 1, 20, 1);
    for (int n = 0; n < 100 && beats_acc[1] < 10; n++) step();
    check("mid_beats", 64'(beats_acc[1]), 64'(10));
    #2;
    async_reset();
    for (int c = 0; c < 2; c++) check("mid_reset_bus", 64'(got_bus(c)), 64'(RESET_BUS));
    check("mid_reset_cnt", 64'({rr_cnt0, rr_cnt1, fp_cnt0, fp_cnt1}), 64'(0));
    step();
    step();
    rst_n = 1'b0;
    start_port(0, 1, 2, 1);
    start_port(1, 1, 2, 1);
    step();
    check("post_reset_grant", 64'({d_grant[0], d_grant[1]}), 64'({2'b01, 2'b01}));
    run_until_idle(100);

    // Counter wrap on the 4-bit instance.
    do_reset();
    start_port(0, 17, 1, 1);
    run_until_idle(500);
    check("wrap_fp_cnt0", 64'(fp_cnt0), 64'(1));
    check("wrap_rr_cnt0", 64'(rr_cnt0), 64'(17));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
